// File: rtl/bsg_front_side_bus_hop_out.sv
`default_nettype none
// ============================================================================
// Module   : bsg_front_side_bus_hop_out
// Function : Round-robin merge of local and pass-through sources onto one
//            outgoing ring link through a 2-entry valid/ready buffer.
// Revision : 1.0
// ============================================================================
module bsg_front_side_bus_hop_out #(
  parameter int width_p = 16
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [1:0]             v_i,
  input  logic [2*width_p-1:0]   data_i,
  output logic [1:0]             yumi_o,
  output logic                   v_o,
  output logic [width_p-1:0]     data_o,
  input  logic                   ready_i
);

  logic [width_p-1:0] r_mem [2];
  logic               r_head;
  logic               r_tail;
  logic               r_empty;
  logic               r_full;
  logic               r_last;

  logic               w_sel;
  logic               w_enq;
  logic               w_deq;
  logic [width_p-1:0] w_word;

  // Space is judged on full alone so that yumi never depends on ready_i.
  always_comb begin
    w_sel  = (v_i == 2'b11) ? ~r_last : v_i[1];
    w_enq  = ~reset_i & ~r_full & (|v_i);
    w_word = w_sel ? data_i[2*width_p-1:width_p] : data_i[width_p-1:0];
    yumi_o = 2'b00;
    if (w_enq) begin
      yumi_o = w_sel ? 2'b10 : 2'b01;
    end
  end

  assign w_deq  = ~r_empty & ready_i;
  assign v_o    = ~r_empty;
  assign data_o = r_mem[r_head];

  always_ff @(posedge clk_i) begin
    if (w_enq) begin
      r_mem[r_tail] <= w_word;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_head  <= 1'b0;
      r_tail  <= 1'b0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
      r_last  <= 1'b1;
    end else begin
      if (w_enq) begin
        r_tail <= ~r_tail;
        r_last <= w_sel;
      end
      if (w_deq) begin
        r_head <= ~r_head;
      end
      if (w_enq && !w_deq) begin
        r_empty <= 1'b0;
        r_full  <= ~r_empty;
      end else if (w_deq && !w_enq) begin
        r_full  <= 1'b0;
        r_empty <= ~r_full;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bsg_front_side_bus_hop_out.sv
`default_nettype none
// Directed bench for bsg_front_side_bus_hop_out; a monitor compares every
// accepted output word against a queue of hand-computed expected words.
module tb_bsg_front_side_bus_hop_out;

  localparam int W = 16;

  logic           clk = 1'b0;
  logic           reset_i;
  logic [1:0]     v_i;
  logic [2*W-1:0] data_i;
  logic [1:0]     yumi_o;
  logic           v_o;
  logic [W-1:0]   data_o;
  logic           ready_i;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] src0_q [$];
  logic [W-1:0] src1_q [$];
  logic [W-1:0] exp_q  [$];

  bsg_front_side_bus_hop_out #(.width_p(W)) dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .v_i     (v_i),
    .data_i  (data_i),
    .yumi_o  (yumi_o),
    .v_o     (v_o),
    .data_o  (data_o),
    .ready_i (ready_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Sources present their queue heads; refreshed just after each clock edge.
  task automatic drive_sources();
    v_i[0] = (src0_q.size() != 0);
    v_i[1] = (src1_q.size() != 0);
    data_i[W-1:0]   = (src0_q.size() != 0) ? src0_q[0] : '0;
    data_i[2*W-1:W] = (src1_q.size() != 0) ? src1_q[0] : '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drive_sources();
    #1;
  endtask

  // Monitor: mid-cycle, consume yumied source words and score transfers.
  always @(negedge clk) begin
    if (reset_i) begin
      checks++;
      if (yumi_o !== 2'b00) begin
        errors++;
        $display("FAIL yumi_in_reset actual=%b required=00 at %0t", yumi_o, $time);
      end
    end
    if (yumi_o[0] === 1'b1 && src0_q.size() != 0) void'(src0_q.pop_front());
    if (yumi_o[1] === 1'b1 && src1_q.size() != 0) void'(src1_q.pop_front());
    if (v_o === 1'b1 && ready_i === 1'b1 && reset_i === 1'b0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output actual=%h required=none at %0t", data_o, $time);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (data_o !== e) begin
          errors++;
          $display("FAIL out_word actual=%h required=%h at %0t", data_o, e, $time);
        end
      end
    end
  end

  initial begin
    logic [1:0] yumi_tab [5];
    reset_i = 1'b1;
    ready_i = 1'b1;
    v_i     = 2'b00;
    data_i  = '0;

    // Reset held with both sources valid
    src0_q.push_back(16'h0A00);
    src1_q.push_back(16'h1A00);
    exp_q.push_back(16'h0A00);
    exp_q.push_back(16'h1A00);
    repeat (3) begin
      tick();
      chk("reset_yumi", {30'd0, yumi_o}, 32'h0);
      chk("reset_v", {31'd0, v_o}, 32'h0);
    end
    reset_i = 1'b0;
    #1;
    chk("first_grant_src0", {30'd0, yumi_o}, 32'h1);
    tick();
    chk("second_grant_src1", {30'd0, yumi_o}, 32'h2);
    chk("reset_seq_v", {31'd0, v_o}, 32'h1);
    tick();
    chk("reset_seq_idle_yumi", {30'd0, yumi_o}, 32'h0);
    tick();
    chk("reset_seq_drain", {31'd0, v_o}, 32'h0);

    // Contention: alternating grants, one word per cycle
    src0_q.push_back(16'h0001); src0_q.push_back(16'h0002);
    src1_q.push_back(16'h1001); src1_q.push_back(16'h1002);
    exp_q.push_back(16'h0001); exp_q.push_back(16'h1001);
    exp_q.push_back(16'h0002); exp_q.push_back(16'h1002);
    yumi_tab[0] = 2'b01; yumi_tab[1] = 2'b10; yumi_tab[2] = 2'b01;
    yumi_tab[3] = 2'b10; yumi_tab[4] = 2'b00;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("contend_yumi", {30'd0, yumi_o}, {30'd0, yumi_tab[c]});
      chk("contend_v", {31'd0, v_o}, (c == 0) ? 32'h0 : 32'h1);
    end
    tick();
    chk("contend_drain", {31'd0, v_o}, 32'h0);

    // Single source, latency one cycle
    src0_q.push_back(16'hA5A5);
    exp_q.push_back(16'hA5A5);
    tick();
    chk("single_yumi", {30'd0, yumi_o}, 32'h1);
    chk("single_v_n", {31'd0, v_o}, 32'h0);
    tick();
    chk("single_v_n1", {31'd0, v_o}, 32'h1);
    chk("single_data", {16'd0, data_o}, 32'hA5A5);
    chk("single_no_yumi", {30'd0, yumi_o}, 32'h0);
    tick();

    // Back-pressure, then full with simultaneous dequeue
    ready_i = 1'b0;
    src1_q.push_back(16'h00B0); src1_q.push_back(16'h00B1); src1_q.push_back(16'h00B2);
    exp_q.push_back(16'h00B0); exp_q.push_back(16'h00B1); exp_q.push_back(16'h00B2);
    tick();
    chk("bp_yumi0", {30'd0, yumi_o}, 32'h2);
    tick();
    chk("bp_yumi1", {30'd0, yumi_o}, 32'h2);
    tick();
    chk("bp_full_yumi", {30'd0, yumi_o}, 32'h0);
    tick();
    chk("bp_full_hold", {30'd0, yumi_o}, 32'h0);
    ready_i = 1'b1;
    #1;
    chk("full_deq_no_yumi", {30'd0, yumi_o}, 32'h0);
    chk("bp_head_b0", {16'd0, data_o}, 32'h00B0);
    tick();
    chk("full_deq_next_yumi", {30'd0, yumi_o}, 32'h2);
    chk("bp_head_b1", {16'd0, data_o}, 32'h00B1);
    tick();
    chk("bp_head_b2", {16'd0, data_o}, 32'h00B2);
    tick();
    chk("bp_drain", {31'd0, v_o}, 32'h0);

    // Mid-stream reset discards buffered words
    ready_i = 1'b0;
    src0_q.push_back(16'h00C0);
    src1_q.push_back(16'h00C1);
    tick();
    chk("mid_yumi0", {30'd0, yumi_o}, 32'h1);
    tick();
    chk("mid_yumi1", {30'd0, yumi_o}, 32'h2);
    tick();
    chk("mid_full_v", {31'd0, v_o}, 32'h1);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    ready_i = 1'b1;
    #1;
    chk("mid_after_reset_v", {31'd0, v_o}, 32'h0);
    repeat (3) begin
      tick();
      chk("mid_no_emit", {31'd0, v_o}, 32'h0);
    end

    chk("exp_queue_empty", exp_q.size(), 32'h0);
    chk("sources_drained", src0_q.size() + src1_q.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
